// File: rtl/sprite_scan_ctrl_if.sv
// Pixel stream interface between sprite_scan_ctrl and the LCD pixel sink.
//   px_valid : pixel available (source -> sink)
//   px_ready : sink accepts pixel; transfer when valid & ready (sink -> source)
//   px_data  : RGB565 pixel (source -> sink)
//   px_last  : final pixel of the frame (source -> sink)
interface sprite_scan_ctrl_if;
  logic        px_valid;
  logic        px_ready;
  logic [15:0] px_data;
  logic        px_last;

  modport master (output px_valid, output px_data, output px_last, input px_ready);
  modport slave  (input px_valid, input px_data, input px_last, output px_ready);
endinterface

// File: rtl/sprite_scan_ctrl.sv
// sprite_scan_ctrl
// Turns one latched 8x8 monochrome sprite (bit 63 = row0/col0) into a raster
// RGB565 pixel stream by stepping an external combinational 64:1 bit mux.
// Each sprite pixel is replicated SCALE times horizontally and each sprite
// row SCALE times vertically.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start_i      : frame request, honoured only in IDLE
//   sprite_i     : sprite bitmap, latched on the accepted start edge
//   busy_o       : high in STREAM and DONE
//   done_o       : one-cycle pulse after the last pixel is accepted
//   mux_data_o   : latched sprite, feeds the mux data input
//   mux_sel_o    : mux select {1'b0, row, col}
//   mux_bit_i    : combinational mux return
//   px (master)  : valid/ready pixel stream with last marker
module sprite_scan_ctrl #(
  parameter int unsigned SCALE    = 4,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [63:0]                sprite_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [63:0]                mux_data_o,
  output logic [6:0]                 mux_sel_o,
  input  logic                       mux_bit_i,
  sprite_scan_ctrl_if.master         px
);

  localparam int unsigned CW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CW-1:0] REP_MAX = CW'(SCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   sprite_q, sprite_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] hrep_q, hrep_d;
  logic [CW-1:0] vrep_q, vrep_d;

  logic streaming;
  logic xfer;
  logic hrep_wrap, col_wrap, vrep_wrap, row_wrap;
  logic last_px;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sprite_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      hrep_q   <= '0;
      vrep_q   <= '0;
    end else begin
      state_q  <= state_d;
      sprite_q <= sprite_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hrep_q   <= hrep_d;
      vrep_q   <= vrep_d;
    end
  end

  assign streaming = (state_q == S_STREAM);
  assign xfer      = streaming && px.px_ready;
  assign hrep_wrap = (hrep_q == REP_MAX);
  assign col_wrap  = (col_q == 3'd7);
  assign vrep_wrap = (vrep_q == REP_MAX);
  assign row_wrap  = (row_q == 3'd7);
  assign last_px   = streaming && hrep_wrap && col_wrap && vrep_wrap && row_wrap;

  always_comb begin
    state_d  = state_q;
    sprite_d = sprite_q;
    col_d    = col_q;
    row_d    = row_q;
    hrep_d   = hrep_q;
    vrep_d   = vrep_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_STREAM;
          sprite_d = sprite_i;
          col_d    = '0;
          row_d    = '0;
          hrep_d   = '0;
          vrep_d   = '0;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          // Nested raster counters; the final transfer wraps all four back
          // to zero, so mux_sel_o is already 0 when IDLE is reached.
          if (hrep_wrap) begin
            hrep_d = '0;
            if (col_wrap) begin
              col_d = '0;
              if (vrep_wrap) begin
                vrep_d = '0;
                row_d  = row_q + 3'd1;
              end else begin
                vrep_d = vrep_q + CW'(1);
              end
            end else begin
              col_d = col_q + 3'd1;
            end
          end else begin
            hrep_d = hrep_q + CW'(1);
          end
          if (last_px) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mux_data_o  = sprite_q;
  assign mux_sel_o   = {1'b0, row_q, col_q};
  assign px.px_valid = streaming;
  assign px.px_last  = last_px;
  assign px.px_data  = mux_bit_i ? FG_COLOR : BG_COLOR;

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
// Bench for sprite_scan_ctrl: three instances at SCALE 1, 2 and 4 share
// clk/rst/sprite/ready; each has its own start line and its own mux model.
// Expected pixels are generated from the sprite when a frame is started and
// compared against the pixel at the head of the queue every valid cycle.
module tb_sprite_scan_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [3];
  logic [63:0] sprite_r;
  logic        ready_r;

  logic        busy  [3];
  logic        done  [3];
  logic        mbit  [3];
  logic        vld   [3];
  logic        lst   [3];
  logic [15:0] pdat  [3];
  logic [63:0] mdata [3];
  logic [6:0]  msel  [3];

  sprite_scan_ctrl_if p0 ();
  sprite_scan_ctrl_if p1 ();
  sprite_scan_ctrl_if p2 ();

  assign p0.px_ready = ready_r;
  assign p1.px_ready = ready_r;
  assign p2.px_ready = ready_r;
  assign vld[0]  = p0.px_valid;
  assign vld[1]  = p1.px_valid;
  assign vld[2]  = p2.px_valid;
  assign lst[0]  = p0.px_last;
  assign lst[1]  = p1.px_last;
  assign lst[2]  = p2.px_last;
  assign pdat[0] = p0.px_data;
  assign pdat[1] = p1.px_data;
  assign pdat[2] = p2.px_data;

  // Mux model: select 0 picks bit 63 (row0/col0).
  for (genvar k = 0; k < 3; k++) begin : g_mux
    assign mbit[k] = mdata[k][6'd63 - msel[k][5:0]];
  end

  sprite_scan_ctrl #(.SCALE(1), .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)) u_s1 (
    .clk(clk), .rst(rst), .start_i(start[0]), .sprite_i(sprite_r),
    .busy_o(busy[0]), .done_o(done[0]), .mux_data_o(mdata[0]), .mux_sel_o(msel[0]),
    .mux_bit_i(mbit[0]), .px(p0)
  );
  sprite_scan_ctrl #(.SCALE(2), .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)) u_s2 (
    .clk(clk), .rst(rst), .start_i(start[1]), .sprite_i(sprite_r),
    .busy_o(busy[1]), .done_o(done[1]), .mux_data_o(mdata[1]), .mux_sel_o(msel[1]),
    .mux_bit_i(mbit[1]), .px(p1)
  );
  sprite_scan_ctrl #(.SCALE(4), .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)) u_s4 (
    .clk(clk), .rst(rst), .start_i(start[2]), .sprite_i(sprite_r),
    .busy_o(busy[2]), .done_o(done[2]), .mux_data_o(mdata[2]), .mux_sel_o(msel[2]),
    .mux_bit_i(mbit[2]), .px(p2)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [6:0]  sel;
  } exp_px_t;

  typedef struct {
    int          d;
    logic [63:0] spr;
    int          mode;        // 0: ready always high, 1: pseudo-random ready
    int          restart_at;  // transfer index at which start is re-pulsed, -1 none
    bit          sid;         // pulse start during the DONE cycle
  } vec_t;

  exp_px_t exp_q[$];
  int      checks = 0;
  int      errors = 0;

  function automatic int scale_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input int s, input logic [63:0] spr);
    exp_px_t e;
    int idx;
    for (int r = 0; r < 8; r++)
      for (int vr = 0; vr < s; vr++)
        for (int c = 0; c < 8; c++)
          for (int hr = 0; hr < s; hr++) begin
            idx    = r * 8 + c;
            e.data = spr[63 - idx] ? 16'hFFFF : 16'h0000;
            e.last = (r == 7) && (vr == s - 1) && (c == 7) && (hr == s - 1);
            e.sel  = 7'(idx);
            exp_q.push_back(e);
          end
  endtask

  // Ends at posedge+1 after the start edge; sprite_i is then scrambled so a
  // design that does not latch the sprite shows wrong pixels.
  task automatic start_frame(input int d, input logic [63:0] spr);
    exp_q.delete();
    push_expected(scale_of(d), spr);
    sprite_r = spr;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    sprite_r = {$urandom, $urandom};
  endtask

  task automatic stream_frame(input int d, input int mode, input int restart_at, input int abort_at);
    int s, got, cyc, total, budget;
    bit pulsed;
    s      = scale_of(d);
    got    = 0;
    cyc    = 0;
    pulsed = 1'b0;
    total  = (abort_at >= 0) ? abort_at : 64 * s * s;
    budget = 4 * 64 * s * s + 16;
    while (got < total && cyc < budget) begin
      ready_r  = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      start[d] = (restart_at >= 0) && (got == restart_at) && !pulsed;
      if (start[d]) pulsed = 1'b1;
      @(negedge clk);
      chk("px_valid", 64'(vld[d]), 64'd1);
      chk("busy_stream", 64'(busy[d]), 64'd1);
      chk("done_stream", 64'(done[d]), 64'd0);
      if (exp_q.size() > 0) begin
        chk("px_data", 64'(pdat[d]), 64'(exp_q[0].data));
        chk("px_last", 64'(lst[d]), 64'(exp_q[0].last));
        chk("mux_sel", 64'(msel[d]), 64'(exp_q[0].sel));
      end
      if (ready_r && vld[d]) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      cyc++;
    end
    if (got < total) chk("frame_timeout", 64'(got), 64'(total));
  endtask

  task automatic finish_frame(input int d, input logic [63:0] spr, input bit sid);
    start[d] = sid;
    @(negedge clk);
    chk("done_pulse", 64'(done[d]), 64'd1);
    chk("busy_done", 64'(busy[d]), 64'd1);
    chk("valid_done", 64'(vld[d]), 64'd0);
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    @(negedge clk);
    chk("done_idle", 64'(done[d]), 64'd0);
    chk("busy_idle", 64'(busy[d]), 64'd0);
    chk("valid_idle", 64'(vld[d]), 64'd0);
    chk("sel_idle", 64'(msel[d]), 64'd0);
    chk("mux_data_kept", mdata[d], spr);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("still_idle", 64'(vld[d]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{d: 0, spr: 64'h8000_0000_0000_0001, mode: 0, restart_at: -1, sid: 1'b0};
    vecs[1] = '{d: 1, spr: 64'hC000_0000_0000_0000, mode: 0, restart_at: -1, sid: 1'b0};
    vecs[2] = '{d: 0, spr: 64'hA5A5_0F0F_3C3C_FF00, mode: 1, restart_at: -1, sid: 1'b0};
    vecs[3] = '{d: 0, spr: 64'h0123_4567_89AB_CDEF, mode: 0, restart_at: 10, sid: 1'b1};
    vecs[4] = '{d: 0, spr: 64'hF0E1_D2C3_B4A5_9687, mode: 1, restart_at: -1, sid: 1'b0};
    vecs[5] = '{d: 2, spr: 64'h1824_4281_8142_2418, mode: 1, restart_at: -1, sid: 1'b0};

    rst      = 1'b1;
    ready_r  = 1'b0;
    sprite_r = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_done", 64'(done[k]), 64'd0);
      chk("rst_valid", 64'(vld[k]), 64'd0);
      chk("rst_last", 64'(lst[k]), 64'd0);
      chk("rst_sel", 64'(msel[k]), 64'd0);
      chk("rst_mux_data", mdata[k], 64'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].d, vecs[i].spr);
      stream_frame(vecs[i].d, vecs[i].mode, vecs[i].restart_at, -1);
      finish_frame(vecs[i].d, vecs[i].spr, vecs[i].sid);
    end

    // Reset mid-frame at pixel 20 of a SCALE=4 frame, then a full frame.
    start_frame(2, 64'hFFFF_0000_FFFF_0000);
    stream_frame(2, 0, -1, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_valid", 64'(vld[2]), 64'd0);
    chk("rst_mid_busy", 64'(busy[2]), 64'd0);
    chk("rst_mid_sel", 64'(msel[2]), 64'd0);
    chk("rst_mid_done", 64'(done[2]), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_no_done", 64'(done[2]), 64'd0);
    @(posedge clk);
    #1;
    start_frame(2, 64'h0F1E_2D3C_4B5A_6978);
    stream_frame(2, 0, -1, -1);
    finish_frame(2, 64'h0F1E_2D3C_4B5A_6978, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
